inst_fetch_ctrl: RTL and testbench
==================================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'd0, meaning the first fetch address after reset.
REQ-002 The block SHALL expose parameter DEPTH, default 2, legal values 2 or 4, meaning the prefetch buffer entry count.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_addr  output  32  byte address driven to the combinational instruction memory.
REQ-006 imem_inst  input  32  instruction word returned by instruction memory in the same cycle as imem_addr.
REQ-007 branch_taken  input  1  redirect request from execute stage.
REQ-008 branch_addr  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-009 freeze  input  1  hazard stall; suppresses new fetches only.
REQ-010 out_valid  output  1  buffer head holds a valid instruction.
REQ-011 out_inst  output  32  instruction at buffer head.
REQ-012 out_pc  output  32  fetch address of the head instruction plus 4.
REQ-013 out_ready  input  1  decode accepts the head this cycle.
REQ-014 fetch_count  output  16  number of instructions pushed since reset, wrapping.

Function
REQ-015 The block SHALL implement states BOOT, RUN and REDIRECT.
REQ-016 BOOT is entered on reset; BOOT->RUN unconditionally on the next edge, with no fetch pushed in BOOT.
REQ-017 imem_addr SHALL equal fetch_pc combinationally in every state.
REQ-018 In RUN, a push SHALL occur when freeze=0, branch_taken=0, and (count<DEPTH or a pop occurs the same cycle); a push stores {imem_inst, fetch_pc+4} and advances fetch_pc by 4.
REQ-019 fetch_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-020 A pop SHALL occur when out_valid=1 and out_ready=1; out_valid SHALL be 1 exactly when count>0.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH and count=0 (no bypass: at count=0 the pushed entry appears on the next cycle).
REQ-022 branch_taken=1 in RUN or REDIRECT SHALL, on the edge: empty the buffer, set fetch_pc to {branch_addr[31:2],2'b00}, suppress push and pop, and enter REDIRECT; it overrides freeze and out_ready.
REQ-023 REDIRECT SHALL last one cycle (a one-cycle bubble with no push), then enter RUN unless branch_taken is asserted again.
REQ-024 freeze=1 SHALL hold fetch_pc and block pushes but SHALL NOT block pops.
REQ-025 out_inst/out_pc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 fetch_count SHALL increment by 1 per push and wrap from 16'hFFFF to 0.
REQ-027 Buffer overflow and underflow SHALL be impossible by construction; count SHALL never exceed DEPTH.

Reset
REQ-028 While rst_n=0: state=BOOT, fetch_pc=RESET_PC, count=0, out_valid=0, out_inst=0, out_pc=0, fetch_count=0, imem_addr=RESET_PC.
REQ-029 Reset assertion mid-operation SHALL discard all buffered entries immediately, independent of clk.

Verification
REQ-030 Reset release, out_ready=1, memory returns addr-derived words -> first out_valid two edges after release, with out_pc=4, 8, 12 on consecutive cycles.
REQ-031 out_ready=0 for 10 cycles with DEPTH=2 -> count saturates at 2, fetch_pc stops at 8, head out_pc stays 4; fetch resumes on the first pop.
REQ-032 branch_taken with branch_addr=32'h0000_0103 while buffer is full -> buffer empties, imem_addr=0x100 during the bubble cycle, next head out_pc=0x104.
REQ-033 freeze=1 with 2 entries buffered and out_ready=1 -> both drain over 2 cycles, out_valid=0 afterward, fetch_pc unchanged.
REQ-034 RESET_PC=32'hFFFF_FFF8 with free-running fetch -> pushes from 0xFFFFFFF8, 0xFFFFFFFC, 0x0; out_pc sequence 0xFFFFFFFC, 0x0, 0x4.
REQ-035 rst_n pulsed low mid-stream with 2 entries buffered -> out_valid drops asynchronously, fetch_count=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory port, redirect/stall controls and the decode-facing head.
// The master modport is the fetch controller; the slave modport is its surroundings.
interface inst_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        freeze;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [15:0] fetch_count;

  modport master (
    output imem_addr, out_valid, out_inst, out_pc, fetch_count,
    input  imem_inst, branch_taken, branch_addr, freeze, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_inst, out_pc, fetch_count,
    output imem_inst, branch_taken, branch_addr, freeze, out_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: drives a combinational instruction memory and queues
// {inst, pc+4} pairs in a small prefetch buffer, with branch redirect and hazard freeze.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_fetch_ctrl_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_e;

  state_e          state_q;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [31:0]     inst_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];
  logic [15:0]     fetch_count_q;
  logic            valid_q;
  logic            push, pop, redirect;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^bus.branch_addr[1:0];

  // Redirect wins over everything: it blocks both push and pop for the cycle.
  always_comb begin
    redirect   = (state_q != BOOT) && bus.branch_taken;
    pop        = valid_q && bus.out_ready && !redirect;
    push       = (state_q == RUN) && !bus.freeze && !bus.branch_taken &&
                 ((count_q < CW'(DEPTH)) || pop);
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    fetch_pc_d = push ? fetch_pc_q + 32'd4 : fetch_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      valid_q       <= 1'b0;
      fetch_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        BOOT:          state_q <= RUN;
        RUN, REDIRECT: state_q <= redirect ? REDIRECT : RUN;
        default:       state_q <= BOOT;
      endcase

      if (redirect) begin
        fetch_pc_q <= {bus.branch_addr[31:2], 2'b00};
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        valid_q    <= 1'b0;
      end else begin
        fetch_pc_q <= fetch_pc_d;
        count_q    <= count_d;
        valid_q    <= (count_d != '0);
        if (push) begin
          inst_q[wr_ptr_q] <= bus.imem_inst;
          pc_q[wr_ptr_q]   <= fetch_pc_q + 32'd4;
          wr_ptr_q         <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      end

      fetch_count_q <= fetch_count_q + 16'(push);
    end
  end

  assign bus.imem_addr   = fetch_pc_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_inst    = inst_q[rd_ptr_q];
  assign bus.out_pc      = pc_q[rd_ptr_q];
  assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench: directed scenarios push expected head PCs; a negedge monitor checks every accepted head.
module tb_inst_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_fetch_ctrl_if bus0 ();
  inst_fetch_ctrl_if bus1 ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign bus0.imem_inst = mem_word(bus0.imem_addr);
  assign bus1.imem_inst = mem_word(bus1.imem_addr);

  assign bus1.branch_taken = 1'b0;
  assign bus1.branch_addr  = 32'd0;
  assign bus1.freeze       = 1'b0;
  assign bus1.out_ready    = 1'b1;

  inst_fetch_ctrl #(.RESET_PC(32'd0), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus0.out_valid && bus0.out_ready && !bus0.branch_taken) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got pc %h expected no pop", bus0.out_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", bus0.out_pc, e);
        chk("pop_inst", bus0.out_inst, mem_word(e - 32'd4));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus0.branch_taken = 1'b0;
    bus0.branch_addr  = 32'd0;
    bus0.freeze       = 1'b0;
    bus0.out_ready    = 1'b0;

    repeat (2) @(posedge clk); #1;
    chk("rst_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_inst", bus0.out_inst, 32'd0);
    chk("rst_pc", bus0.out_pc, 32'd0);
    chk("rst_count", 32'(bus0.fetch_count), 32'd0);
    chk("rst_addr", bus0.imem_addr, 32'd0);
    chk("rst_addr_wrap", bus1.imem_addr, 32'hFFFF_FFF8);

    // Boot latency and the wrapping instance
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("boot_valid", 32'(bus0.out_valid), 32'd0);
    chk("boot_valid_wrap", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    chk("first_valid", 32'(bus0.out_valid), 32'd1);
    chk("first_pc", bus0.out_pc, 32'd4);
    chk("first_inst", bus0.out_inst, mem_word(32'd0));
    chk("wrap_pc0", bus1.out_pc, 32'hFFFF_FFFC);
    chk("wrap_inst0", bus1.out_inst, mem_word(32'hFFFF_FFF8));
    @(negedge clk);
    chk("wrap_pc1", bus1.out_pc, 32'd0);
    @(negedge clk);
    chk("wrap_pc2", bus1.out_pc, 32'd4);
    chk("wrap_inst2", bus1.out_inst, mem_word(32'd0));

    // Backpressure: buffer saturates at two entries
    repeat (10) @(posedge clk); #1;
    chk("full_valid", 32'(bus0.out_valid), 32'd1);
    chk("full_pc", bus0.out_pc, 32'd4);
    chk("full_addr", bus0.imem_addr, 32'd8);
    chk("full_count", 32'(bus0.fetch_count), 32'd2);

    exp_q.push_back(32'd4);  exp_q.push_back(32'd8);
    exp_q.push_back(32'd12); exp_q.push_back(32'd16);
    bus0.out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    chk("stream_count", 32'(bus0.fetch_count), 32'd6);
    chk("stream_addr", bus0.imem_addr, 32'd24);
    chk("stream_head", bus0.out_pc, 32'd20);

    // Redirect while full
    bus0.branch_taken = 1'b1;
    bus0.branch_addr  = 32'h0000_0103;
    @(posedge clk); #1;
    bus0.branch_taken = 1'b0;
    chk("br_flush_valid", 32'(bus0.out_valid), 32'd0);
    chk("br_addr", bus0.imem_addr, 32'h100);
    @(posedge clk); #1;
    chk("bubble_valid", 32'(bus0.out_valid), 32'd0);
    chk("bubble_addr", bus0.imem_addr, 32'h100);
    chk("bubble_count", 32'(bus0.fetch_count), 32'd6);
    @(posedge clk); #1;
    chk("br_head_valid", 32'(bus0.out_valid), 32'd1);
    chk("br_head_pc", bus0.out_pc, 32'h104);
    chk("br_head_inst", bus0.out_inst, mem_word(32'h100));
    @(posedge clk); #1;
    chk("br_full_addr", bus0.imem_addr, 32'h108);

    // Freeze drains but does not fetch
    bus0.freeze = 1'b1;
    exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    bus0.out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("frz_empty", 32'(bus0.out_valid), 32'd0);
    repeat (2) @(posedge clk); #1;
    chk("frz_still_empty", 32'(bus0.out_valid), 32'd0);
    chk("frz_addr", bus0.imem_addr, 32'h108);
    chk("frz_count", 32'(bus0.fetch_count), 32'd8);

    bus0.freeze = 1'b0;
    exp_q.push_back(32'h10C); exp_q.push_back(32'h110);
    repeat (3) @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("resume_valid", 32'(bus0.out_valid), 32'd1);
    chk("resume_head", bus0.out_pc, 32'h114);
    chk("resume_addr", bus0.imem_addr, 32'h118);
    chk("resume_count", 32'(bus0.fetch_count), 32'd12);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus0.out_valid), 32'd0);
    chk("arst_count", 32'(bus0.fetch_count), 32'd0);
    chk("arst_addr", bus0.imem_addr, 32'd0);
    chk("arst_pc", bus0.out_pc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    bus0.out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    chk("restart_count", 32'(bus0.fetch_count), 32'd3);
    chk("restart_addr", bus0.imem_addr, 32'd12);

    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
